// File: rtl/uart_cmd_decoder_if.sv
// rtl/uart_cmd_decoder_if.sv - byte-stream input and channel command outputs of the UART command decoder
interface uart_cmd_decoder_if #(
    parameter int NUM_CH = 2,
    parameter int CMD_W  = 16,
    parameter int ERR_W  = 8
);
    logic                      rx_dv;
    logic [7:0]                rx_byte;
    logic [NUM_CH-1:0]         cmd_clear;
    logic [NUM_CH*CMD_W-1:0]   cmd;
    logic [NUM_CH-1:0]         cmd_set;
    logic                      cmd_stb;
    logic                      frame_err;
    logic [ERR_W-1:0]          err_cnt;
    logic                      busy;

    modport master (
        output rx_dv, rx_byte, cmd_clear,
        input  cmd, cmd_set, cmd_stb, frame_err, err_cnt, busy
    );

    modport slave (
        input  rx_dv, rx_byte, cmd_clear,
        output cmd, cmd_set, cmd_stb, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - parses "!<ch><hex digits><CR>" frames into per-channel command registers
module uart_cmd_decoder #(
    parameter int NUM_CH       = 2,
    parameter int NUM_DIGITS   = 4,
    parameter int TIMEOUT_CLKS = 43400,
    parameter int ERR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_decoder_if.slave bus
);
    localparam int CMD_W = 4 * NUM_DIGITS;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DC_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(NUM_DIGITS - 1);
    localparam logic [7:0]      CH_LAST = 8'(8'h41 + NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, CHAN, DATA, TERM} state_t;

    state_t            state, state_nxt;
    logic [CMD_W-1:0]  acc, acc_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic              bcast, bcast_nxt;
    logic [DC_W-1:0]   dcnt, dcnt_nxt;
    logic [TO_W-1:0]   tcnt;
    logic              commit, abort, timeout;
    logic              is_hex;
    logic [3:0]        nib;
    logic [7:0]        b;

    assign b = bus.rx_byte;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = (TIMEOUT_CLKS != 0) && (state != IDLE) && !bus.rx_dv && (tcnt == TO_LAST);

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            is_hex = 1'b1;
            nib    = b[3:0];
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = b[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ch_nxt    = ch;
        bcast_nxt = bcast;
        dcnt_nxt  = dcnt;
        commit    = 1'b0;
        abort     = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            abort     = 1'b1;
        end else if (bus.rx_dv) begin
            case (state)
                IDLE: if (b == 8'h21) state_nxt = CHAN;
                CHAN: begin
                    if (b >= 8'h41 && b <= CH_LAST) begin
                        state_nxt = DATA;
                        ch_nxt    = CH_W'(b - 8'h41);
                        bcast_nxt = 1'b0;
                        acc_nxt   = '0;
                        dcnt_nxt  = '0;
                    end else if (b == 8'h2A) begin
                        state_nxt = DATA;
                        ch_nxt    = '0;
                        bcast_nxt = 1'b1;
                        acc_nxt   = '0;
                        dcnt_nxt  = '0;
                    end else if (b != 8'h21) begin
                        state_nxt = IDLE;
                        abort     = 1'b1;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        acc_nxt  = (acc << 4) | CMD_W'(nib);
                        dcnt_nxt = dcnt + 1'b1;
                        if (dcnt == DC_LAST) state_nxt = TERM;
                    end else begin
                        state_nxt = (b == 8'h21) ? CHAN : IDLE;
                        abort     = 1'b1;
                    end
                end
                TERM: begin
                    if (b == 8'h0D) begin
                        state_nxt = IDLE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = (b == 8'h21) ? CHAN : IDLE;
                        abort     = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            ch            <= '0;
            bcast         <= 1'b0;
            dcnt          <= '0;
            tcnt          <= '0;
            bus.cmd       <= '0;
            bus.cmd_set   <= '0;
            bus.cmd_stb   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.err_cnt   <= '0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            ch            <= ch_nxt;
            bcast         <= bcast_nxt;
            dcnt          <= dcnt_nxt;
            tcnt          <= (bus.rx_dv || state_nxt == IDLE) ? '0 : tcnt + 1'b1;
            bus.cmd_stb   <= commit;
            bus.frame_err <= abort;
            bus.busy      <= (state_nxt != IDLE);
            if (abort && bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + 1'b1;
            // Commit takes priority over an acknowledge landing on the same edge.
            for (int k = 0; k < NUM_CH; k++) begin
                if (commit && (bcast || ch == CH_W'(k))) begin
                    bus.cmd[k*CMD_W +: CMD_W] <= acc;
                    bus.cmd_set[k]            <= 1'b1;
                end else if (bus.cmd_clear[k]) begin
                    bus.cmd_set[k]            <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   stb_cnt = 0;
    int   err_pulses = 0;
    int   overlap_cnt = 0;

    uart_cmd_decoder_if #(.NUM_CH(2), .CMD_W(16), .ERR_W(8)) bus0 ();
    uart_cmd_decoder_if #(.NUM_CH(2), .CMD_W(16), .ERR_W(2)) bus1 ();

    assign bus1.rx_dv     = bus0.rx_dv;
    assign bus1.rx_byte   = bus0.rx_byte;
    assign bus1.cmd_clear = bus0.cmd_clear;

    uart_cmd_decoder #(.NUM_CH(2), .NUM_DIGITS(4), .TIMEOUT_CLKS(100), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_cmd_decoder #(.NUM_CH(2), .NUM_DIGITS(4), .TIMEOUT_CLKS(100), .ERR_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.cmd_stb) stb_cnt++;
            if (bus0.frame_err) err_pulses++;
            if (bus0.cmd_stb && bus0.frame_err) overlap_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] bv);
        bus0.rx_byte = bv;
        bus0.rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        bus0.rx_dv   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus0.rx_dv     = 1'b0;
        bus0.rx_byte   = 8'h00;
        bus0.cmd_clear = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("reset_cmd", bus0.cmd, 32'h0);
        chk("reset_cmd_set", bus0.cmd_set, 2'b00);
        chk("reset_cmd_stb", bus0.cmd_stb, 1'b0);
        chk("reset_frame_err", bus0.frame_err, 1'b0);
        chk("reset_err_cnt", bus0.err_cnt, 8'd0);
        chk("reset_busy", bus0.busy, 1'b0);

        // Frame to channel A with mixed-case hex, checking strobe latency
        send_str("!A");
        chk("t1_busy_mid", bus0.busy, 1'b1);
        send_str("12aF");
        chk("t1_stb_before_cr", bus0.cmd_stb, 1'b0);
        send_byte(8'h0D);
        chk("t1_stb_after_cr", bus0.cmd_stb, 1'b1);
        chk("t1_cmd", bus0.cmd, 32'h0000_12AF);
        chk("t1_cmd_set", bus0.cmd_set, 2'b01);
        chk("t1_busy_done", bus0.busy, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_stb_one_cycle", bus0.cmd_stb, 1'b0);
        chk("t1_err_cnt", bus0.err_cnt, 8'd0);

        // Broadcast, then acknowledge channel B only
        send_str("!*0030\r");
        chk("t2_cmd", bus0.cmd, 32'h0030_0030);
        chk("t2_cmd_set", bus0.cmd_set, 2'b11);
        bus0.cmd_clear = 2'b10;
        @(posedge clk);
        #1;
        bus0.cmd_clear = 2'b00;
        chk("t2_cmd_set_clr", bus0.cmd_set, 2'b01);
        chk("t2_cmd_kept", bus0.cmd, 32'h0030_0030);
        chk("t2_stb_total", stb_cnt, 2);

        // Three malformed frames
        send_str("!C1234\r");
        send_str("!B12G4\r");
        send_str("!B1234\n");
        chk("t3_err_pulses", err_pulses, 3);
        chk("t3_err_cnt", bus0.err_cnt, 8'd3);
        chk("t3_cmd", bus0.cmd, 32'h0030_0030);
        chk("t3_cmd_set", bus0.cmd_set, 2'b01);
        chk("t3_no_commit", stb_cnt, 2);

        // Resync on '!' in the middle of a frame
        bus0.cmd_clear = 2'b11;
        @(posedge clk);
        #1;
        bus0.cmd_clear = 2'b00;
        chk("t4_pre_cmd_set", bus0.cmd_set, 2'b00);
        send_str("!B12!A0001\r");
        chk("t4_err_pulses", err_pulses, 4);
        chk("t4_cmd", bus0.cmd, 32'h0030_0001);
        chk("t4_cmd_set", bus0.cmd_set, 2'b01);
        chk("t4_err_cnt", bus0.err_cnt, 8'd4);

        // Inter-byte timeout of 100 clocks
        send_str("!A1");
        send_byte("2");
        repeat (99) @(posedge clk);
        #1;
        chk("t5_busy_before_expiry", bus0.busy, 1'b1);
        chk("t5_no_err_before_expiry", bus0.frame_err, 1'b0);
        @(posedge clk);
        #1;
        chk("t5_timeout_err", bus0.frame_err, 1'b1);
        chk("t5_busy_after", bus0.busy, 1'b0);
        send_str("34\r");
        chk("t5_no_commit", stb_cnt, 3);
        chk("t5_cmd", bus0.cmd, 32'h0030_0001);
        chk("t5_err_cnt", bus0.err_cnt, 8'd5);
        chk("t6_err_cnt_saturated", bus1.err_cnt, 2'd3);

        // Commit and acknowledge to channel A on the same edge
        bus0.cmd_clear = 2'b01;
        @(posedge clk);
        #1;
        bus0.cmd_clear = 2'b00;
        chk("t6_pre_cmd_set", bus0.cmd_set, 2'b00);
        send_str("!A00FF");
        bus0.cmd_clear = 2'b01;
        send_byte(8'h0D);
        bus0.cmd_clear = 2'b00;
        chk("t6_commit_wins", bus0.cmd_set, 2'b01);
        chk("t6_cmd", bus0.cmd, 32'h0030_00FF);

        // Reset in the middle of a frame
        @(posedge clk);
        #1;
        send_str("!B12");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_rst_cmd", bus0.cmd, 32'h0);
        chk("t6_rst_cmd_set", bus0.cmd_set, 2'b00);
        chk("t6_rst_err_cnt", bus0.err_cnt, 8'd0);
        chk("t6_rst_busy", bus0.busy, 1'b0);
        chk("t6_rst_err_cnt_sat", bus1.err_cnt, 2'd0);
        send_str("!BABCD\r");
        chk("t6_post_rst_cmd", bus0.cmd, 32'hABCD_0000);
        chk("t6_post_rst_cmd_set", bus0.cmd_set, 2'b10);
        chk("t6_post_rst_err_cnt", bus0.err_cnt, 8'd0);
        chk("no_stb_err_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
